mvm_accel_unit: RTL and testbench

- Accelerator end of the CPU's MVM/DIC instruction pair; sits beside the register file and write-back mux.
- MVM instructions issued by the controller load a 4x4 signed weight matrix and a 4-element vector, start a sequential matrix-vector multiply, or clear the unit.
- DIC instructions read one 16-bit result element, which the CPU writes back through its write-back source select 110.
- The unit stalls the CPU while a computation is in flight.

---
 rtl/mvm_accel_unit.sv | 145 ++++++++++++++
 tb/tb_mvm_accel_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_accel_unit.sv
// rtl/mvm_accel_unit.sv - matrix-vector multiply accelerator behind the MVM/DIC instruction pair
module mvm_accel_unit #(
  parameter int N      = 4,
  parameter int ELEM_W = 8,
  parameter int RES_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [15:0] rs_data,
  output logic        stall,
  output logic [15:0] dic_data,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] OP_MVM  = 5'b11111;
  localparam logic [4:0] OP_DIC  = 5'b11110;
  localparam logic [1:0] SUB_LDW = 2'b00;
  localparam logic [1:0] SUB_LDV = 2'b01;
  localparam logic [1:0] SUB_GO  = 2'b10;
  localparam logic [1:0] SUB_CLR = 2'b11;
  localparam logic [1:0] LAST    = 2'(N - 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t state;

  // Operand and result storage
  logic signed [ELEM_W-1:0] w [N][N];
  logic signed [ELEM_W-1:0] v [N];
  logic signed [RES_W-1:0]  r [N];
  logic signed [RES_W-1:0]  acc;
  logic [1:0]               row_cnt;
  logic [1:0]               col_cnt;

  // Instruction fields
  logic       is_mvm;
  logic       is_dic;
  logic       mvm_go;
  logic [1:0] sub_op;
  logic [1:0] f_row;
  logic [1:0] f_col;
  logic [ELEM_W-1:0] elem;

  // MAC datapath
  logic signed [RES_W-1:0] prod;
  logic signed [RES_W-1:0] acc_next;

  logic unused;

  assign is_mvm = (instr[15:11] == OP_MVM);
  assign is_dic = (instr[15:11] == OP_DIC);
  assign sub_op = instr[10:9];
  assign f_row  = instr[7:6];
  assign f_col  = instr[5:4];
  assign elem   = rs_data[ELEM_W-1:0];
  assign unused = ^{instr[8], instr[3:0], rs_data[15:ELEM_W]};

  // MVM instructions only take effect when the unit is not computing;
  // otherwise they are stalled and re-presented by the CPU.
  assign mvm_go = instr_valid && is_mvm && !busy;
  assign stall  = instr_valid && busy && (is_mvm || is_dic);

  // Both operands are widened before multiplying so the full signed product fits.
  assign prod     = RES_W'(w[row_cnt][col_cnt]) * RES_W'(v[col_cnt]);
  assign acc_next = ((col_cnt == 2'd0) ? '0 : acc) + prod;

  assign dic_data = (instr_valid && is_dic && !stall) ? 16'(r[f_col]) : 16'd0;

  // Control FSM, operand loads and the sequential MAC walk (col inner, row outer)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      row_cnt <= 2'd0;
      col_cnt <= 2'd0;
      acc     <= '0;
      for (int i = 0; i < N; i++) begin
        v[i] <= '0;
        r[i] <= '0;
        for (int j = 0; j < N; j++) begin
          w[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (mvm_go) begin
            case (sub_op)
              SUB_LDW: w[f_row][f_col] <= elem;
              SUB_LDV: v[f_col] <= elem;
              SUB_GO: begin
                state   <= CALC;
                busy    <= 1'b1;
                done    <= 1'b0;
                row_cnt <= 2'd0;
                col_cnt <= 2'd0;
                acc     <= '0;
              end
              SUB_CLR: begin
                done <= 1'b0;
                for (int i = 0; i < N; i++) begin
                  v[i] <= '0;
                  r[i] <= '0;
                  for (int j = 0; j < N; j++) begin
                    w[i][j] <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= acc_next;
          if (col_cnt == LAST) begin
            r[row_cnt] <= acc_next;
            col_cnt    <= 2'd0;
            if (row_cnt == LAST) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              row_cnt <= 2'd0;
            end else begin
              row_cnt <= row_cnt + 2'd1;
            end
          end else begin
            col_cnt <= col_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_accel_unit.sv
// tb/tb_mvm_accel_unit.sv - self-checking bench for mvm_accel_unit
module tb_mvm_accel_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] rs_data;
  logic        stall;
  logic [15:0] dic_data;
  logic        busy;
  logic        done;

  mvm_accel_unit dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .rs_data    (rs_data),
    .stall      (stall),
    .dic_data   (dic_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wm [4][4];
  int vm [4];
  logic [15:0] rm [4];
  logic [15:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mvm_op(input logic [1:0] op, input logic [1:0] row, input logic [1:0] col);
    return {5'b11111, op, 1'b0, row, col, 4'b0000};
  endfunction

  function automatic logic [15:0] dic_op(input logic [1:0] idx);
    return {5'b11110, 5'b00000, idx, 4'b0000};
  endfunction

  task automatic compute_model;
    for (int i = 0; i < 4; i++) begin
      int s;
      s = 0;
      for (int j = 0; j < 4; j++) s += wm[i][j] * vm[j];
      rm[i] = s[15:0];
    end
  endtask

  task automatic zero_model;
    for (int i = 0; i < 4; i++) begin
      vm[i] = 0;
      rm[i] = '0;
      for (int j = 0; j < 4; j++) wm[i][j] = 0;
    end
  endtask

  // Present an MVM instruction, hold it while stalled, return one cycle after it is accepted
  task automatic issue_mvm(input logic [1:0] op, input logic [1:0] row, input logic [1:0] col, input logic [15:0] data);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr       = mvm_op(op, row, col);
    rs_data     = data;
    @(negedge clk);
    while (stall && n < 40) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    check_eq("mvm_accept", stall, 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
    rs_data     = '0;
    case (op)
      2'b00: wm[row][col] = $signed(data[7:0]);
      2'b01: vm[col] = $signed(data[7:0]);
      2'b10: compute_model();
      default: zero_model();
    endcase
  endtask

  // DIC read: expectation queued when driven, compared when the DUT stops stalling
  task automatic dic_read(input logic [1:0] idx, input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr       = dic_op(idx);
    exp_q.push_back(exp);
    @(negedge clk);
    while (stall && n < 40) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_stall"}, stall, 0);
    check_eq(tag, dic_data, exp_q.pop_front());
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++) dic_read(2'(i), rm[i], $sformatf("%s_r%0d", tag, i));
  endtask

  // Called one cycle after START acceptance: busy for 16 cycles, then done
  task automatic wait_run_timed(input string tag);
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        instr_valid = 1'b1;
        instr       = 16'h1234;
      end
      @(negedge clk);
      check_eq($sformatf("%s_busy_T%0d", tag, k), busy, 1);
      if (k == 1) check_eq({tag, "_done_low"}, done, 0);
      if (k == 3) check_eq({tag, "_other_nostall"}, stall, 0);
      @(posedge clk);
      #1;
      if (k == 3) begin
        instr_valid = 1'b0;
        instr       = '0;
      end
    end
    @(negedge clk);
    check_eq({tag, "_busy_end"}, busy, 0);
    check_eq({tag, "_done_end"}, done, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw [4];
    int sv [4];
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    rs_data = '0;
    zero_model();
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_dic", dic_data, 0);
    tick();
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'h0000, $sformatf("prestart_r%0d", i));

    // Identity matrix, V = 1..4
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        issue_mvm(2'b00, 2'(i), 2'(j), (i == j) ? 16'd1 : 16'd0);
    for (int j = 0; j < 4; j++) issue_mvm(2'b01, 2'd0, 2'(j), 16'(j + 1));
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("ident");
    dic_read(2'd0, 16'd1, "ident_r0");
    dic_read(2'd1, 16'd2, "ident_r1");
    dic_read(2'd2, 16'd3, "ident_r2");
    dic_read(2'd3, 16'd4, "ident_r3");

    // Signed extremes in row 0
    sw = '{-128, 127, -1, 2};
    sv = '{-128, 1, -1, 5};
    for (int j = 0; j < 4; j++) issue_mvm(2'b00, 2'd0, 2'(j), 16'(sw[j]));
    for (int j = 0; j < 4; j++) issue_mvm(2'b01, 2'd0, 2'(j), 16'(sv[j]));
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("signed");
    dic_read(2'd0, 16'h408A, "signed_r0");
    read_all("signed");

    // Accumulator wrap
    for (int j = 0; j < 4; j++) issue_mvm(2'b00, 2'd0, 2'(j), 16'hFF80);
    for (int j = 0; j < 4; j++) issue_mvm(2'b01, 2'd0, 2'(j), 16'hFF80);
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("wrap");
    dic_read(2'd0, 16'h0000, "wrap_r0");
    read_all("wrap");

    // DIC held from T+5 stalls through T+16
    for (int j = 0; j < 4; j++) issue_mvm(2'b00, 2'd2, 2'(j), 16'(j * 3 - 5));
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    repeat (4) tick();
    instr_valid = 1'b1;
    instr = dic_op(2'd2);
    exp_q.push_back(rm[2]);
    for (int k = 5; k <= 16; k++) begin
      @(negedge clk);
      check_eq($sformatf("dic_stall_T%0d", k), stall, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("dic_stall_T17", stall, 0);
    check_eq("dic_held_r2", dic_data, exp_q.pop_front());
    tick();
    instr_valid = 1'b0;
    instr = '0;

    // LDW during CALC is held off until the run completes
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    tick();
    issue_mvm(2'b00, 2'd1, 2'd1, 16'd9);
    check_eq("ldw_after_done", done, 1);
    read_all("ldw_held");
    compute_model();
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("ldw_new");
    read_all("ldw_new");

    // Reset in the middle of a run
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    tick();
    zero_model();
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'h0000, $sformatf("midrst_r%0d", i));
    for (int i = 0; i < 4; i++) begin
      issue_mvm(2'b00, 2'(i), 2'(3 - i), 16'(i + 2));
      issue_mvm(2'b01, 2'd0, 2'(i), 16'(10 - 7 * i));
    end
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("postrst");
    read_all("postrst");

    // CLR after a completed run
    issue_mvm(2'b11, 2'd0, 2'd0, 16'd0);
    @(negedge clk);
    check_eq("clr_done", done, 0);
    tick();
    issue_mvm(2'b10, 2'd0, 2'd0, 16'd0);
    wait_run_timed("clr");
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'h0000, $sformatf("clr_r%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
